vram_write_buffer: RTL and testbench



---
 rtl/vram_write_buffer.sv | 119 +++++++++++
 tb/tb_vram_write_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_buffer.sv
// Write buffer between the rasterizer's VRAM strobes and a req/ack memory port.
// Define VRAM_WRITE_BUFFER_STATS_EN to add the drop counter and fill high-water mark.
module vram_write_buffer #(
   parameter int DEPTH              = 16,
   parameter int ADDR_WIDTH         = 16,
   parameter int DATA_WIDTH         = 16,
   parameter int ALMOST_FULL_MARGIN = 4
) (
   input  logic                    clk,
   input  logic                    reset_i,
   input  logic                    vram_sel_i,
   input  logic                    vram_wr_i,
   input  logic [3:0]              vram_mask_i,
   input  logic [ADDR_WIDTH-1:0]   vram_addr_i,
   input  logic [DATA_WIDTH-1:0]   vram_data_i,
   output logic                    full_o,
   output logic                    almost_full_o,
   output logic                    idle_o,
   output logic                    overflow_o,
   output logic                    mem_req_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_data_o,
   output logic [3:0]              mem_mask_o,
`ifdef VRAM_WRITE_BUFFER_STATS_EN
   output logic [15:0]             drop_count_o,
   output logic [$clog2(DEPTH):0]  max_fill_o,
`endif
   input  logic                    mem_ack_i
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 4 + ADDR_WIDTH + DATA_WIDTH;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t                state_q, state_d;
   logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count, count_d;
   logic                  push_req, push, pop, drop;

   assign push_req      = vram_sel_i & vram_wr_i;
   assign full_o        = (count == CNT_W'(DEPTH));
   assign almost_full_o = (32'(DEPTH) - 32'(count)) <= 32'(ALMOST_FULL_MARGIN);
   assign push          = push_req & ~full_o;
   assign drop          = push_req & full_o;

   // Drain FSM: state register
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Drain FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (count != '0) state_d = S_ISSUE;
         S_ISSUE: if (mem_ack_i && count == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Drain FSM: outputs; ack only matters while a request is outstanding
   always_comb begin
      pop       = (count != '0) && ((state_q == S_IDLE) || mem_ack_i);
      mem_req_o = (state_q == S_ISSUE);
      idle_o    = (state_q == S_IDLE) && (count == '0);
   end

   always_comb begin
      count_d = count;
      if (push && !pop)      count_d = count + CNT_W'(1);
      else if (pop && !push) count_d = count - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_d;
         if (drop) overflow_o <= 1'b1;
      end
   end

   // Storage carries no reset; only pointers and count define validity
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {vram_mask_i, vram_addr_i, vram_data_i};
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         mem_mask_o <= '0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
      end else if (pop) begin
         {mem_mask_o, mem_addr_o, mem_data_o} <= fifo_mem[rd_ptr];
      end
   end

`ifdef VRAM_WRITE_BUFFER_STATS_EN
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         drop_count_o <= '0;
         max_fill_o   <= '0;
      end else begin
         if (drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
         if (count_d > max_fill_o)             max_fill_o   <= count_d;
      end
   end
`endif

endmodule

// File: tb/tb_vram_write_buffer.sv
// Randomized and directed bench for vram_write_buffer against a queue-based model.
module tb_vram_write_buffer;

   localparam int DEPTH = 16;
   localparam int MARGIN = 4;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        vram_sel_i = 1'b0, vram_wr_i = 1'b0;
   logic [3:0]  vram_mask_i = '0;
   logic [15:0] vram_addr_i = '0, vram_data_i = '0;
   logic        full_o, almost_full_o, idle_o, overflow_o, mem_req_o;
   logic [15:0] mem_addr_o, mem_data_o;
   logic [3:0]  mem_mask_o;
   logic        mem_ack_i = 1'b0;
`ifdef VRAM_WRITE_BUFFER_STATS_EN
   logic [15:0] drop_count_o;
   logic [4:0]  max_fill_o;
`endif

   vram_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(16), .DATA_WIDTH(16),
                       .ALMOST_FULL_MARGIN(MARGIN)) dut (
      .clk(clk), .reset_i(reset_i),
      .vram_sel_i(vram_sel_i), .vram_wr_i(vram_wr_i), .vram_mask_i(vram_mask_i),
      .vram_addr_i(vram_addr_i), .vram_data_i(vram_data_i),
      .full_o(full_o), .almost_full_o(almost_full_o), .idle_o(idle_o),
      .overflow_o(overflow_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o),
`ifdef VRAM_WRITE_BUFFER_STATS_EN
      .drop_count_o(drop_count_o), .max_fill_o(max_fill_o),
`endif
      .mem_ack_i(mem_ack_i));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: a queue of waiting writes plus one in-flight write
   typedef struct packed {logic [3:0] m; logic [15:0] a; logic [15:0] d;} ent_t;
   ent_t        mq[$];
   ent_t        m_fl;
   bit          m_busy, m_ovf;
   int          m_n;
   bit          m_stb, m_ack;
   logic [15:0] dlog[$];
   bit          cmp_en = 1'b0;

   always @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         mq.delete();
         m_busy = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         m_n   = mq.size();
         m_stb = vram_sel_i && vram_wr_i;
         m_ack = mem_ack_i && m_busy;
         if (m_n > 0 && (!m_busy || m_ack)) begin
            m_fl   = mq.pop_front();
            m_busy = 1'b1;
         end else if (m_ack) begin
            m_busy = 1'b0;
         end
         if (m_stb) begin
            if (m_n < DEPTH) mq.push_back('{m: vram_mask_i, a: vram_addr_i, d: vram_data_i});
            else             m_ovf = 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (!reset_i && mem_req_o && mem_ack_i) dlog.push_back(mem_addr_o);
   end

   always @(negedge clk) begin
      if (cmp_en && !reset_i) begin
         chk("m_req", 32'(mem_req_o), 32'(m_busy));
         if (m_busy) begin
            chk("m_addr", 32'(mem_addr_o), 32'(m_fl.a));
            chk("m_data", 32'(mem_data_o), 32'(m_fl.d));
            chk("m_mask", 32'(mem_mask_o), 32'(m_fl.m));
         end
         chk("m_full", 32'(full_o), 32'(mq.size() == DEPTH));
         chk("m_afull", 32'(almost_full_o), 32'((DEPTH - mq.size()) <= MARGIN));
         chk("m_idle", 32'(idle_o), 32'(!m_busy && mq.size() == 0));
         chk("m_ovf", 32'(overflow_o), 32'(m_ovf));
      end
   end

   task automatic cyc(input bit s, input logic [15:0] a, input logic [15:0] d,
                      input logic [3:0] m, input bit ack);
      vram_sel_i = s; vram_wr_i = s; vram_addr_i = a; vram_data_i = d;
      vram_mask_i = m; mem_ack_i = ack;
      @(negedge clk);
   endtask

   task automatic do_reset();
      vram_sel_i = 0; vram_wr_i = 0; mem_ack_i = 0;
      reset_i = 1'b1;
      @(negedge clk); @(negedge clk);
      reset_i = 1'b0;
      dlog.delete();
   endtask

   task automatic drain(input int budget);
      int k = 0;
      vram_sel_i = 0; vram_wr_i = 0; mem_ack_i = 1;
      while (!idle_o && k < budget) begin @(negedge clk); k++; end
      chk("drain_done", 32'(idle_o), 32'd1);
      mem_ack_i = 0;
   endtask

   initial begin
      int hi;
      @(negedge clk);
      do_reset();
      chk("rst_req", 32'(mem_req_o), 0);
      chk("rst_addr", 32'(mem_addr_o), 0);
      chk("rst_data", 32'(mem_data_o), 0);
      chk("rst_mask", 32'(mem_mask_o), 0);
      chk("rst_idle", 32'(idle_o), 1);
      chk("rst_full", 32'(full_o), 0);
      chk("rst_afull", 32'(almost_full_o), 0);
      chk("rst_ovf", 32'(overflow_o), 0);
      cmp_en = 1'b1;

      // Single write: request rises after E+1, ack three cycles later
      cyc(1, 16'h0012, 16'hF0A5, 4'hF, 0);
      chk("sw_req_E", 32'(mem_req_o), 0);
      cyc(0, 0, 0, 0, 0);
      chk("sw_req", 32'(mem_req_o), 1);
      chk("sw_addr", 32'(mem_addr_o), 32'h0012);
      chk("sw_data", 32'(mem_data_o), 32'hF0A5);
      chk("sw_mask", 32'(mem_mask_o), 32'hF);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("sw_hold", 32'(mem_req_o), 1);
      cyc(0, 0, 0, 0, 1);
      mem_ack_i = 0;
      chk("sw_drop", 32'(mem_req_o), 0);
      chk("sw_idle", 32'(idle_o), 1);
      chk("sw_ovf", 32'(overflow_o), 0);

      // Overflow: 20 strobes with ack held low, 17 kept
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cyc(1, 16'(i), 16'($urandom), 4'($urandom), 0);
         if (i == 15) chk("ov_full16", 32'(full_o), 0);
         if (i == 16) chk("ov_full17", 32'(full_o), 1);
      end
      chk("ov_ovf", 32'(overflow_o), 1);
`ifdef VRAM_WRITE_BUFFER_STATS_EN
      chk("ov_drops", 32'(drop_count_o), 3);
      chk("ov_maxfill", 32'(max_fill_o), 16);
`endif
      drain(100);
      chk("ov_nlog", 32'(dlog.size()), 17);
      for (int i = 0; i < dlog.size() && i < 17; i++) chk("ov_order", 32'(dlog[i]), 32'(i));

      // Throughput: ack tied high, one write per cycle
      do_reset();
      hi = 0;
      for (int i = 0; i < 68; i++) begin
         cyc(i < 64, 16'(i), 16'h0, 4'hF, 1);
         if (mem_req_o) hi++;
      end
      mem_ack_i = 0;
      chk("tp_hi", 32'(hi), 64);
      chk("tp_nlog", 32'(dlog.size()), 64);
      for (int i = 0; i < dlog.size() && i < 64; i++) chk("tp_order", 32'(dlog[i]), 32'(i));
      chk("tp_ovf", 32'(overflow_o), 0);

      // Almost-full threshold at count 12
      do_reset();
      for (int i = 0; i < 13; i++) begin
         cyc(1, 16'(i), 16'(i), 4'h3, 0);
         if (i == 11) chk("af_c11", 32'(almost_full_o), 0);
         if (i == 12) chk("af_c12", 32'(almost_full_o), 1);
      end
      cyc(0, 0, 0, 0, 1);
      chk("af_back11", 32'(almost_full_o), 0);
      drain(100);

      // Push and pop on the same edge while full
      do_reset();
      for (int i = 0; i < 17; i++) cyc(1, 16'(i), 16'(i), 4'h1, 0);
      chk("pp_full", 32'(full_o), 1);
      chk("pp_ovf0", 32'(overflow_o), 0);
      cyc(1, 16'd99, 16'd99, 4'h1, 1);
      chk("pp_full_after", 32'(full_o), 0);
      chk("pp_ovf1", 32'(overflow_o), 1);
      chk("pp_afull", 32'(almost_full_o), 1);
      drain(100);
      chk("pp_nlog", 32'(dlog.size()), 17);
      for (int i = 0; i < dlog.size() && i < 17; i++) chk("pp_order", 32'(dlog[i]), 32'(i));

      // Asynchronous reset with writes in flight
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1, 16'(i + 40), 16'(i), 4'h7, 0);
      chk("mr_req_pre", 32'(mem_req_o), 1);
      vram_sel_i = 0; vram_wr_i = 0;
      #2 reset_i = 1'b1;
      #1 chk("mr_req_async", 32'(mem_req_o), 0);
      @(negedge clk);
      reset_i = 1'b0;
      dlog.delete();
      chk("mr_idle", 32'(idle_o), 1);
      chk("mr_full", 32'(full_o), 0);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 0, 1);
         if (mem_req_o) hi++;
      end
      chk("mr_no_stale", 32'(hi), 0);
      chk("mr_nlog", 32'(dlog.size()), 0);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         vram_sel_i  = ($urandom_range(0, 9) < 8);
         vram_wr_i   = ($urandom_range(0, 9) < 8);
         vram_addr_i = 16'($urandom);
         vram_data_i = 16'($urandom);
         vram_mask_i = 4'($urandom);
         mem_ack_i   = ($urandom_range(0, 9) < (i < 1500 ? 4 : 7));
         @(negedge clk);
      end
      drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
